allo_sched: RTL
===============

ALLO_SCHED -- requirements
Module: allo_sched

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3; FIFO depth = 2**DEPTH_LOG2 entries.
REQ-002 SHALL have port clk  input  1  global Speech256 clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port host_data  input  6  allophone code from host.
REQ-005 SHALL have port host_wr  input  1  one-cycle write strobe for host_data.
REQ-006 SHALL have port host_full  output  1  high when FIFO holds DEPTH entries.
REQ-007 SHALL have port overflow  output  1  sticky flag; write attempted while full.
REQ-008 SHALL have port fill  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-009 SHALL have port ldq  input  1  sequencer load request; high = ready for an allophone.
REQ-010 SHALL have port data_out  output  6  allophone presented to the sequencer.
REQ-011 SHALL have port data_stb  output  1  one-cycle strobe; data_out valid.
REQ-012 SHALL have port busy  output  1  high when FIFO non-empty or state not S_IDLE.
REQ-013 SHALL have port flush  input  1  clear FIFO (present only with ALLO_SCHED_FLUSH_EN).

Function
REQ-014 SHALL implement a circular FIFO with wr_ptr, rd_ptr (DEPTH_LOG2 bits, wrap modulo DEPTH) and a separate count.
REQ-015 SHALL accept host_wr when not full, or when full and a pop occurs in the same cycle.
REQ-016 SHALL drop host_wr when full without pop, leave FIFO unchanged, and set overflow until reset.
REQ-017 SHALL, on simultaneous push and pop, keep fill unchanged and advance both pointers.
REQ-018 SHALL have states S_IDLE, S_STROBE, S_ACK.
REQ-019 S_IDLE: if ldq=1 and fill>0, SHALL register data_out from FIFO head, pop, and go to S_STROBE.
REQ-020 S_STROBE: SHALL drive data_stb=1 for exactly this one cycle and go to S_ACK.
REQ-021 S_ACK: SHALL hold data_stb=0 and return to S_IDLE only after sampling ldq=0.
REQ-022 SHALL never assert data_stb in consecutive cycles; at most one strobe per ldq high period.
REQ-023 SHALL keep data_out stable from S_STROBE until the next pop.
REQ-024 Latency: fill>0 and ldq=1 sampled at edge N -> data_stb high during cycle N+1.
REQ-025 Writes to an empty FIFO SHALL be visible to S_IDLE one cycle after the write edge.
REQ-026 host_full and fill SHALL be registered-state derived, with no combinational path from host_wr.
REQ-027 illegal state encodings SHALL go to S_IDLE.

Reset
REQ-028 rst=1 SHALL asynchronously force S_IDLE, pointers=0, fill=0, host_full=0, overflow=0, data_out=0, data_stb=0, busy=0.
REQ-029 reset mid-handshake SHALL discard queued and in-flight allophones; no strobe SHALL be issued until after rst falls and ldq=1 is sampled.

Configuration
REQ-030 macro ALLO_SCHED_FLUSH_EN defined: flush=1 SHALL synchronously zero pointers and fill, drop same-cycle host_wr, and force S_IDLE; overflow is unaffected; a strobe in S_STROBE that cycle still completes.
REQ-031 macro ALLO_SCHED_FLUSH_EN undefined: flush port and logic SHALL be absent; the FIFO empties only by pops or reset.

Verification
REQ-032 write 0x2A with ldq=1 held -> data_stb one cycle at N+1 with data_out=0x2A; no further strobe while ldq stays 1.
REQ-033 write 0x01,0x02,0x03; toggle ldq low 2 cycles, high 20 cycles each -> three strobes in order 0x01,0x02,0x03, one per ldq high period; busy falls after the third handshake.
REQ-034 DEPTH_LOG2=3, ldq=0, 9 writes -> host_full=1 after 8, 9th dropped, overflow=1, fill=8; then drain -> 8 values in write order.
REQ-035 full FIFO, host_wr coincident with pop -> write accepted, fill stays 8, overflow stays 0.
REQ-036 rst pulse during S_ACK with fill=3 -> all outputs at reset values immediately; after release and ldq=1, no strobe until a new write.
REQ-037 ALLO_SCHED_FLUSH_EN defined: fill=5, flush with host_wr -> fill=0, no strobe follows; undefined build compiles without flush port.

Source files
------------

// File: rtl/allo_sched_if.sv
// Host-write / sequencer-load bundle for the allophone scheduler.
// The flush signal exists only when ALLO_SCHED_FLUSH_EN is defined.
interface allo_sched_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic [5:0]          host_data;
  logic                host_wr;
  logic                host_full;
  logic                overflow;
  logic [DEPTH_LOG2:0] fill;
  logic                ldq;
  logic [5:0]          data_out;
  logic                data_stb;
  logic                busy;
`ifdef ALLO_SCHED_FLUSH_EN
  logic                flush;
`endif

  // Host and sequencer side.
  modport master (
    output host_data, host_wr, ldq,
`ifdef ALLO_SCHED_FLUSH_EN
    output flush,
`endif
    input  host_full, overflow, fill, data_out, data_stb, busy
  );

  // Scheduler side.
  modport slave (
    input  host_data, host_wr, ldq,
`ifdef ALLO_SCHED_FLUSH_EN
    input  flush,
`endif
    output host_full, overflow, fill, data_out, data_stb, busy
  );
endinterface

// File: rtl/allo_sched.sv
// Allophone scheduler: host FIFO feeding a strobe/ack handshake to the sequencer.
// Optional synchronous FIFO clear enabled by defining ALLO_SCHED_FLUSH_EN.
module allo_sched #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  allo_sched_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t                state;
  logic [5:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [5:0]            data_q;
  logic                  stb_q;
  logic                  overflow_q;

  logic clr;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

`ifdef ALLO_SCHED_FLUSH_EN
  assign clr = bus.flush;
`else
  assign clr = 1'b0;
`endif

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign pop   = (state == S_IDLE) && bus.ldq && !empty && !clr;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push  = bus.host_wr && (!full || pop) && !clr;
  assign drop  = bus.host_wr && full && !pop && !clr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count,
  // so stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.host_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      data_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            data_q <= mem[rd_ptr];
            stb_q  <= 1'b1;
            state  <= S_STROBE;
          end
        end
        S_STROBE: state <= clr ? S_IDLE : S_ACK;
        // Wait for the sequencer to drop ldq so one high period yields one strobe.
        S_ACK: begin
          if (clr || !bus.ldq) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.fill      = count;
  assign bus.host_full = full;
  assign bus.overflow  = overflow_q;
  assign bus.data_out  = data_q;
  assign bus.data_stb  = stb_q;
  assign bus.busy      = !empty || (state != S_IDLE);
endmodule
